// File: rtl/photon_pkg.sv
// photon_pkg: shared FSM encoding, LFSR polynomial/seed and register reset defaults
// for photon_pulse_gen.
package photon_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, HIGH, DEAD} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;
  localparam logic [7:0] DEF_WIDTH_RST = 8'd1;
  localparam logic [7:0] DEF_DEAD_RST = 8'd30;
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/photon_pulse_gen_if.sv
// photon_pulse_gen_if: configuration, run-control and status bundle; cfg_periodic
// exists only when PULSE_GEN_PERIODIC_EN is defined.
interface photon_pulse_gen_if;
  logic cfg_valid;
  logic cfg_ready;
  logic [7:0] cfg_width;
  logic [7:0] cfg_dead;
  logic [15:0] cfg_thresh;
  logic [15:0] cfg_count;
`ifdef PULSE_GEN_PERIODIC_EN
  logic cfg_periodic;
`endif
  logic start;
  logic stop;
  logic pulse_out;
  logic busy;
  logic done;
  logic [15:0] emitted;
  modport master (
`ifdef PULSE_GEN_PERIODIC_EN
    output cfg_periodic,
`endif
    output cfg_valid, cfg_width, cfg_dead, cfg_thresh, cfg_count, start, stop,
    input cfg_ready, pulse_out, busy, done, emitted
  );
  modport slave (
`ifdef PULSE_GEN_PERIODIC_EN
    input cfg_periodic,
`endif
    input cfg_valid, cfg_width, cfg_dead, cfg_thresh, cfg_count, start, stop,
    output cfg_ready, pulse_out, busy, done, emitted
  );
endinterface

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11); loads seed on reset, steps when en.
module lfsr16 import photon_pkg::*; (
  input logic clk,
  input logic rst_n,
  input logic en,
  input logic [15:0] seed,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (!rst_n) q <= seed;
    else if (en) q <= lfsr_next(q);
endmodule

// File: rtl/photon_pulse_gen.sv
// photon_pulse_gen: emulated single-photon detector line firing on an LFSR compare;
// PULSE_GEN_PERIODIC_EN adds cfg_periodic for fixed-interval firing.
module photon_pulse_gen import photon_pkg::*; #(
  parameter logic [15:0] LFSR_SEED = photon_pkg::LFSR_DEF_SEED,
  parameter logic [7:0] DEF_WIDTH = photon_pkg::DEF_WIDTH_RST,
  parameter logic [7:0] DEF_DEAD = photon_pkg::DEF_DEAD_RST
) (
  input logic clk,
  input logic rst_n,
  photon_pulse_gen_if.slave bus
);
  state_t r_state;
  logic [7:0] r_width, r_dead, r_cnt;
  logic [15:0] r_thresh, r_count, r_emitted;
  logic r_pulse, r_done, r_busy, r_ready;
  logic [15:0] w_lfsr;
  logic w_fire, w_hold, w_last, w_dead_end, w_cfg;
  assign w_cfg = r_state == IDLE && bus.cfg_valid;
  assign w_last = r_count != 16'd0 && r_emitted >= r_count;
  // the last dead cycle doubles as an arming cycle, so pulses can repeat every width+dead
  assign w_dead_end = r_state == DEAD && r_cnt == 8'd1;
`ifdef PULSE_GEN_PERIODIC_EN
  logic r_per;
  logic [15:0] r_acnt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_per <= 1'b0;
      r_acnt <= 16'd0;
    end else begin
      if (w_cfg) r_per <= bus.cfg_periodic;
      r_acnt <= (r_state == ARMED) ? r_acnt + 16'd1 : (w_dead_end ? 16'd1 : 16'd0);
    end
  assign w_hold = r_per;
  assign w_fire = r_per ? r_acnt == ((r_thresh == 16'd0) ? 16'd1 : r_thresh) : w_lfsr < r_thresh;
`else
  assign w_hold = 1'b0;
  assign w_fire = w_lfsr < r_thresh;
`endif
  lfsr16 u_lfsr (
    .clk(clk),
    .rst_n(rst_n),
    .en(r_state != IDLE && !w_hold),
    .seed(LFSR_SEED),
    .q(w_lfsr)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pulse <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_ready <= 1'b1;
      r_emitted <= 16'd0;
      r_cnt <= 8'd0;
      r_width <= DEF_WIDTH;
      r_dead <= DEF_DEAD;
      r_thresh <= 16'd0;
      r_count <= 16'd0;
    end else begin
      r_done <= 1'b0;
      if (w_cfg) begin
        r_width <= bus.cfg_width;
        r_dead <= bus.cfg_dead;
        r_thresh <= bus.cfg_thresh;
        r_count <= bus.cfg_count;
      end
      if (bus.stop) begin
        r_state <= IDLE;
        r_pulse <= 1'b0;
        r_busy <= 1'b0;
        r_ready <= 1'b1;
      end else if (r_state == IDLE) begin
        if (bus.start) begin
          r_state <= ARMED;
          r_emitted <= 16'd0;
          r_busy <= 1'b1;
          r_ready <= 1'b0;
        end
      end else if (r_state == HIGH && r_cnt != 8'd1) begin
        r_cnt <= r_cnt - 8'd1;
      end else if (r_state == HIGH && r_dead != 8'd0) begin
        r_state <= DEAD;
        r_pulse <= 1'b0;
        r_cnt <= r_dead;
      end else if (r_state == DEAD && !w_dead_end) begin
        r_cnt <= r_cnt - 8'd1;
      end else if (r_state != ARMED && w_last) begin
        r_state <= IDLE;
        r_pulse <= 1'b0;
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_ready <= 1'b1;
      end else if (r_state != HIGH && w_fire) begin
        r_state <= HIGH;
        r_pulse <= 1'b1;
        r_cnt <= (r_width == 8'd0) ? 8'd1 : r_width;
        r_emitted <= r_emitted + {15'd0, ~&r_emitted};
      end else begin
        r_state <= ARMED;
        r_pulse <= 1'b0;
      end
    end
  end
  assign bus.cfg_ready = r_ready;
  assign bus.pulse_out = r_pulse;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.emitted = r_emitted;
endmodule

// File: doc/photon_pulse_gen.md
PHOTON_PULSE_GEN -- requirements
Module: photon_pulse_gen

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero reset seed of the random source.
REQ-002 SHALL have parameter DEF_WIDTH, default 8'd1, reset value of the pulse-width register, in cycles.
REQ-003 SHALL have parameter DEF_DEAD, default 8'd30, reset value of the dead-time register, in cycles.
REQ-004 SHALL have port clk  in  1  single 500 MHz clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have ports cfg_valid in 1, cfg_ready out 1: configuration handshake.
REQ-007 SHALL have ports cfg_width in 8 (high cycles), cfg_dead in 8 (dead cycles), cfg_thresh in 16 (fire threshold), cfg_count in 16 (pulses per run, 0 = unlimited).
REQ-008 SHALL have ports start in 1 and stop in 1: run control, level-sampled each cycle.
REQ-009 SHALL have ports pulse_out out 1 (emulated detector line), busy out 1, done out 1 (one-cycle strobe), emitted out 16 (pulses issued this run).

Function
REQ-010 SHALL implement FSM states IDLE, ARMED, HIGH, DEAD; all outputs registered.
REQ-011 SHALL assert cfg_ready only in IDLE; cfg_valid && cfg_ready latches all four cfg fields that cycle.
REQ-012 SHALL ignore cfg_valid outside IDLE, with no change to the latched config.
REQ-013 SHALL, on start in IDLE, clear emitted and enter ARMED next cycle; start while busy is ignored.
REQ-014 SHALL, on simultaneous cfg handshake and start in IDLE, run with the newly latched config.
REQ-015 SHALL advance a 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle in ARMED, HIGH and DEAD, and hold it in IDLE.
REQ-016 SHALL, in ARMED, fire when lfsr < cfg_thresh; pulse_out rises the next cycle; cfg_thresh 0 never fires.
REQ-017 SHALL hold pulse_out high for exactly max(cfg_width,1) cycles in HIGH, then low for exactly cfg_dead cycles in DEAD.
REQ-018 SHALL return to ARMED after DEAD; with cfg_dead 0, go from HIGH directly to ARMED, giving a minimum of one low cycle between pulses.
REQ-019 SHALL increment emitted on each pulse rising edge; emitted saturates at 16'hFFFF.
REQ-020 SHALL, when cfg_count != 0 and emitted reaches cfg_count, finish that pulse's HIGH and DEAD phases, then strobe done for one cycle and enter IDLE.
REQ-021 SHALL never assert done in unlimited mode (cfg_count 0).
REQ-022 SHALL, on stop, enter IDLE next cycle from any state, drive pulse_out low (truncating HIGH), and not assert done; stop has priority over start and over firing.
REQ-023 SHALL drive busy = (state != IDLE).

Reset
REQ-024 SHALL, when rst_n is low at a clock edge, set state to IDLE; pulse_out, done and busy to 0; emitted to 0; lfsr to LFSR_SEED; width to DEF_WIDTH; dead to DEF_DEAD; thresh to 0; count to 0.
REQ-025 SHALL give reset priority over all inputs; reset mid-pulse drops pulse_out the following edge.

Configuration
REQ-026 SHALL support the macro PULSE_GEN_PERIODIC_EN. When it is defined, the module adds input cfg_periodic (1 bit, latched with the other cfg fields). With cfg_periodic set, ARMED fires after exactly cfg_thresh cycles (cfg_thresh 0 is treated as 1) instead of on the LFSR compare, and the LFSR is held. When the macro is undefined, the port is absent and firing is always random.

Structure
REQ-027 SHALL place the state enum, LFSR polynomial/seed constants and DEF_* defaults in shared package photon_pkg.
REQ-028 SHALL instantiate one sub-module, lfsr16, with ports clk, rst_n, en, seed and q.

Verification
REQ-029 SHALL verify reset and defaults: rst_n low 3 cycles, then high -> cfg_ready=1, busy=0, pulse_out=0, emitted=0.
REQ-030 SHALL verify forced firing: cfg_width=2, cfg_dead=5, cfg_thresh=16'hFFFF, cfg_count=3, then start -> three 2-cycle pulses spaced 7 cycles rising-to-rising, and done exactly once, 5 cycles after the third falling edge.
REQ-031 SHALL verify the never-fire case: cfg_thresh=0, start, 1000 cycles -> pulse_out stays 0, busy=1, emitted=0.
REQ-032 SHALL verify stop mid-pulse: cfg_width=10, stop asserted in the 4th high cycle -> pulse_out=0 and busy=0 next cycle, done=0, cfg_ready=1.
REQ-033 SHALL verify the handshake: cfg_valid with cfg_width=7 while busy -> ignored (next run's pulses are max(previous width,1)); cfg_valid with start in IDLE -> pulses are 7 cycles.
REQ-034 SHALL verify the periodic mode with PULSE_GEN_PERIODIC_EN: cfg_periodic=1, cfg_thresh=4, width=1, dead=0 -> rising edges every 6 cycles, identical across LFSR seeds.
